alu_arbiter: RTL and testbench

- Shares one 8-bit combinational ALU (operands a/b, 3-bit opcode, 8-bit result) between two requesters.
- Each requester presents an operation with a valid/ready handshake. The block arbitrates round-robin, registers the operands, waits ALU_LAT cycles, and captures the result.
- The result is returned on a single response channel, tagged with the requester ID.
- Sits between the ALU datapath and the control sources that issue ALU operations.

---
 rtl/alu_arb_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - arb_state_e : controller states (IDLE, EXEC, RESP)
//   - REQ0/REQ1   : requester identifiers as carried on rsp_id_o
//   - DEF_WIDTH/DEF_OPW : default operand and opcode widths
//   - OP_ADD/OP_SUB     : opcodes understood by the reference ALU in the bench
//   - CNT_W       : width of the latency counter (covers ALU_LAT up to 15)
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
//   valid0_i/valid1_i : requests
//   en_i              : grants are only issued while enabled
//   ptr_i             : requester that wins when both request
//   grant0_o/grant1_o : one-hot or zero grant
//   ptr_next_o        : pointer after this cycle's grant (the loser gets priority)
module rr_arbiter2
    import alu_arb_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic en_i,
    input  logic ptr_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic ptr_next_o
);

    logic g0;
    logic g1;

    always_comb begin
        g0 = en_i & valid0_i & (~valid1_i | (ptr_i == REQ0));
        g1 = en_i & valid1_i & (~valid0_i | (ptr_i == REQ1));

        ptr_next_o = ptr_i;
        if (g0) begin
            ptr_next_o = REQ1;
        end else if (g1) begin
            ptr_next_o = REQ0;
        end

        grant0_o = g0;
        grant1_o = g1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// An accepted operation is registered onto alu_*_o, held for ALU_LAT cycles,
// and the ALU result is captured into a single tagged response channel.
//   clk, reset              : clock, synchronous active-high reset
//   reqN_valid_i/ready_o    : request handshake (ready is combinational from valids)
//   reqN_a_i/b_i/op_i       : request operands and opcode
//   alu_a_o/b_o/op_o        : registered operands driven to the ALU
//   alu_res_i               : ALU result
//   rsp_valid_o/ready_i     : response handshake
//   rsp_data_o, rsp_id_o    : captured result and issuing requester
//   busy_o                  : high whenever the controller is not idle
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPW     = DEF_OPW,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [OPW-1:0]   req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [OPW-1:0]   req1_op_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [OPW-1:0]   alu_op_o,
    input  logic [WIDTH-1:0] alu_res_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_id_o,
    output logic             busy_o
);

    // Counter value on the final EXEC cycle, i.e. when the result is sampled.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             busy_q, busy_d;

    logic             grant0;
    logic             grant1;
    logic             ptr_nxt;

    // Grants are only possible in IDLE, so the grants double as the readies.
    rr_arbiter2 u_rr (
        .valid0_i   (req0_valid_i),
        .valid1_i   (req1_valid_i),
        .en_i       (state_q == ST_IDLE),
        .ptr_i      (ptr_q),
        .grant0_o   (grant0),
        .grant1_o   (grant1),
        .ptr_next_o (ptr_nxt)
    );

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    state_d  = ST_EXEC;
                    ptr_d    = ptr_nxt;
                    cnt_d    = '0;
                    id_d     = grant1 ? REQ1 : REQ0;
                    alu_a_d  = grant1 ? req1_a_i  : req0_a_i;
                    alu_b_d  = grant1 ? req1_b_i  : req0_b_i;
                    alu_op_d = grant1 ? req1_op_i : req0_op_i;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_res_i;
                    rsp_id_d    = id_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= REQ0;
            cnt_q       <= '0;
            id_q        <= REQ0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= REQ0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Two instances run side by side: lane 0 with ALU_LAT=1
// and lane 1 with ALU_LAT=4. Each lane has a transaction-level model (countdown
// to the response, pending-response flag, priority pointer) that is compared
// with the DUT every cycle, plus directed scenarios with literal expectations.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk;
    logic       rst [2];
    logic       rdy [2];
    logic       v   [2][2];
    logic [7:0] a   [2][2];
    logic [7:0] b   [2][2];
    logic [2:0] op  [2][2];
    logic       r   [2][2];
    logic [7:0] alu_a   [2];
    logic [7:0] alu_b   [2];
    logic [2:0] alu_op  [2];
    logic [7:0] alu_res [2];
    logic       rv   [2];
    logic [7:0] rd   [2];
    logic       rid  [2];
    logic       busy [2];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit done [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int LAT = (gi == 0) ? 1 : 4;

        alu_arbiter #(.WIDTH(8), .OPW(3), .ALU_LAT(LAT)) dut (
            .clk          (clk),
            .reset        (rst[gi]),
            .req0_valid_i (v[gi][0]),
            .req0_ready_o (r[gi][0]),
            .req0_a_i     (a[gi][0]),
            .req0_b_i     (b[gi][0]),
            .req0_op_i    (op[gi][0]),
            .req1_valid_i (v[gi][1]),
            .req1_ready_o (r[gi][1]),
            .req1_a_i     (a[gi][1]),
            .req1_b_i     (b[gi][1]),
            .req1_op_i    (op[gi][1]),
            .alu_a_o      (alu_a[gi]),
            .alu_b_o      (alu_b[gi]),
            .alu_op_o     (alu_op[gi]),
            .alu_res_i    (alu_res[gi]),
            .rsp_valid_o  (rv[gi]),
            .rsp_ready_i  (rdy[gi]),
            .rsp_data_o   (rd[gi]),
            .rsp_id_o     (rid[gi]),
            .busy_o       (busy[gi])
        );

        assign alu_res[gi] = alu_ref(alu_op[gi], alu_a[gi], alu_b[gi]);

        // Transaction model: 'left' counts execution cycles still to go,
        // 'pend' means a response is waiting for the consumer.
        initial begin : model
            int         left;
            bit         pend;
            int         ptr;
            int         cur;
            int         g;
            bit         live;
            logic [7:0] ea, eb, ed;
            logic [2:0] eo;
            logic       eid;
            left = 0; pend = 0; ptr = 0; cur = 0; live = 0;
            ea = 0; eb = 0; ed = 0; eo = 0; eid = 0;
            forever begin
                @(negedge clk);
                g = -1;
                if (left == 0 && !pend) begin
                    if (v[gi][0] === 1'b1 && v[gi][1] === 1'b1) g = ptr;
                    else if (v[gi][0] === 1'b1)                 g = 0;
                    else if (v[gi][1] === 1'b1)                 g = 1;
                end
                if (live) begin
                    check($sformatf("m%0d_ready0", gi), r[gi][0], g == 0);
                    check($sformatf("m%0d_ready1", gi), r[gi][1], g == 1);
                    check($sformatf("m%0d_busy", gi), busy[gi], (left > 0) || pend);
                    check($sformatf("m%0d_rsp_valid", gi), rv[gi], pend);
                    check($sformatf("m%0d_rsp_data", gi), rd[gi], ed);
                    check($sformatf("m%0d_rsp_id", gi), rid[gi], eid);
                    check($sformatf("m%0d_alu_a", gi), alu_a[gi], ea);
                    check($sformatf("m%0d_alu_b", gi), alu_b[gi], eb);
                    check($sformatf("m%0d_alu_op", gi), alu_op[gi], eo);
                end
                if (rst[gi] === 1'b1) begin
                    live = 1; left = 0; pend = 0; ptr = 0;
                    ea = 0; eb = 0; eo = 0; ed = 0; eid = 0;
                end else if (live) begin
                    if (pend) begin
                        if (rdy[gi] === 1'b1) pend = 0;
                    end else if (left > 0) begin
                        left--;
                        if (left == 0) begin
                            pend = 1;
                            ed   = alu_ref(eo, ea, eb);
                            eid  = (cur == 1);
                        end
                    end else if (g >= 0) begin
                        ea = a[gi][g]; eb = b[gi][g]; eo = op[gi][g];
                        cur = g; left = LAT; ptr = 1 - g;
                    end
                end
            end
        end
    end

    task automatic set_req(input int l, input int q, input logic val,
                           input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] oo);
        v[l][q] = val; a[l][q] = aa; b[l][q] = bb; op[l][q] = oo;
    endtask

    task automatic init_lane(input int l);
        rst[l] = 1'b1;
        rdy[l] = 1'b1;
        for (int q = 0; q < 2; q++) set_req(l, q, 1'b0, 8'h00, 8'h00, 3'b000);
    endtask

    task automatic pulse_reset(input int l);
        @(posedge clk); #1; rst[l] = 1'b1;
        @(posedge clk); #1; rst[l] = 1'b0;
    endtask

    task automatic wait_idle(input int l, input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (busy[l] !== 1'b0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(name, busy[l], 1'b0);
    endtask

    task automatic new_ops(input int l, input int q);
        a[l][q]  = 8'($urandom);
        b[l][q]  = 8'($urandom);
        op[l][q] = 3'($urandom_range(0, 1));
    endtask

    task automatic drive_req(input int l, input int q, input bit acc);
        if (v[l][q] === 1'b1 && acc) begin
            v[l][q] = 1'($urandom_range(0, 1));
            new_ops(l, q);
        end else if (v[l][q] === 1'b1) begin
            if ($urandom_range(0, 15) == 0) v[l][q] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
            v[l][q] = 1'b1;
            new_ops(l, q);
        end
    endtask

    task automatic random_phase(input int l, input int n);
        bit s0, s1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s0 = (r[l][0] === 1'b1);
            s1 = (r[l][1] === 1'b1);
            @(posedge clk); #1;
            rst[l] = ($urandom_range(0, 299) == 0);
            rdy[l] = ($urandom_range(0, 3) != 0);
            drive_req(l, 0, s0);
            drive_req(l, 1, s1);
        end
        @(posedge clk); #1;
        rst[l] = 1'b0; rdy[l] = 1'b1; v[l][0] = 1'b0; v[l][1] = 1'b0;
        wait_idle(l, $sformatf("rand%0d_drain", l));
    endtask

    // Lane 0 (ALU_LAT=1): single request, contention, backpressure, fairness.
    initial begin : lane0
        int         ng, nr, c;
        int         gl [4];
        logic [7:0] dl [2];
        logic       il [2];
        init_lane(0);
        repeat (2) @(posedge clk);
        #1; rst[0] = 1'b0;

        // Single request 0x0F + 0x01.
        set_req(0, 0, 1'b1, 8'h0F, 8'h01, OP_ADD);
        @(negedge clk);
        check("t1_ready0_accept", r[0][0], 1'b1);
        check("t1_busy_idle", busy[0], 1'b0);
        @(posedge clk); #1; v[0][0] = 1'b0;
        @(negedge clk);
        check("t1_busy_exec", busy[0], 1'b1);
        check("t1_no_early_rsp", rv[0], 1'b0);
        @(negedge clk);
        check("t1_rsp_valid", rv[0], 1'b1);
        check("t1_rsp_data", rd[0], 8'h10);
        check("t1_rsp_id", rid[0], 1'b0);
        check("t1_busy_resp", busy[0], 1'b1);
        @(negedge clk);
        check("t1_busy_done", busy[0], 1'b0);

        // Contention: both valid straight out of reset.
        pulse_reset(0);
        set_req(0, 0, 1'b1, 8'h05, 8'h03, OP_ADD);
        set_req(0, 1, 1'b1, 8'h05, 8'h03, OP_SUB);
        ng = 0; nr = 0;
        for (int i = 0; i < 4; i++) gl[i] = 9;
        for (int i = 0; i < 2; i++) begin dl[i] = 8'hxx; il[i] = 1'bx; end
        for (c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (r[0][0] === 1'b1) begin gl[ng] = 0; ng++; end
            if (r[0][1] === 1'b1 && ng < 4) begin gl[ng] = 1; ng++; end
            if (rv[0] === 1'b1 && nr < 2) begin dl[nr] = rd[0]; il[nr] = rid[0]; nr++; end
        end
        for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), gl[i], i % 2);
        check("t2_rsp0_data", dl[0], 8'h08);
        check("t2_rsp0_id", il[0], 1'b0);
        check("t2_rsp1_data", dl[1], 8'h02);
        check("t2_rsp1_id", il[1], 1'b1);
        @(posedge clk); #1; v[0][0] = 1'b0; v[0][1] = 1'b0;
        wait_idle(0, "t2_drain");

        // Backpressure: response held for 10 extra cycles.
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        set_req(0, 1, 1'b1, 8'h20, 8'h22, OP_ADD);
        @(negedge clk);
        check("t3_ready1_accept", r[0][1], 1'b1);
        @(posedge clk); #1; v[0][1] = 1'b0;
        c = 0;
        @(negedge clk);
        while (rv[0] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        check("t3_rsp_arrives", rv[0], 1'b1);
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 8'h11, 8'h22, OP_ADD);
        set_req(0, 1, 1'b1, 8'h33, 8'h44, OP_SUB);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_hold_valid", rv[0], 1'b1);
            check("t3_hold_data", rd[0], 8'h42);
            check("t3_hold_id", rid[0], 1'b1);
            check("t3_ready0_low", r[0][0], 1'b0);
            check("t3_ready1_low", r[0][1], 1'b0);
        end
        @(posedge clk); #1;
        rdy[0] = 1'b1; v[0][0] = 1'b0; v[0][1] = 1'b0;
        @(negedge clk);
        check("t3_complete_cycle", rv[0], 1'b1);
        @(negedge clk);
        check("t3_idle_after", busy[0], 1'b0);
        check("t3_rsp_cleared", rv[0], 1'b0);

        // Fairness: req1 alone, then both -> order 1,0,1.
        pulse_reset(0);
        set_req(0, 1, 1'b1, 8'h0A, 8'h0B, OP_ADD);
        @(negedge clk);
        check("t6_first_grant1", r[0][1], 1'b1);
        check("t6_first_not0", r[0][0], 1'b0);
        @(posedge clk); #1; v[0][1] = 1'b0;
        wait_idle(0, "t6_idle1");
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 8'h01, 8'h02, OP_ADD);
        set_req(0, 1, 1'b1, 8'h03, 8'h04, OP_SUB);
        ng = 0;
        gl[0] = 9; gl[1] = 9;
        for (c = 0; c < 20 && ng < 2; c++) begin
            @(negedge clk);
            if (r[0][0] === 1'b1) begin gl[ng] = 0; ng++; end
            if (r[0][1] === 1'b1 && ng < 2) begin gl[ng] = 1; ng++; end
        end
        check("t6_second_grant", gl[0], 0);
        check("t6_third_grant", gl[1], 1);
        @(posedge clk); #1; v[0][0] = 1'b0; v[0][1] = 1'b0;
        wait_idle(0, "t6_idle2");

        random_phase(0, 2000);
        done[0] = 1'b1;
    end

    // Lane 1 (ALU_LAT=4): long latency with wrap-around, reset during EXEC.
    initial begin : lane1
        bit seen;
        init_lane(1);
        repeat (2) @(posedge clk);
        #1; rst[1] = 1'b0;

        set_req(1, 0, 1'b1, 8'hFF, 8'h01, OP_ADD);
        @(negedge clk);
        check("t4_ready0_accept", r[1][0], 1'b1);
        @(posedge clk); #1;
        set_req(1, 0, 1'b0, 8'h55, 8'hAA, OP_SUB);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_alu_a_stable", alu_a[1], 8'hFF);
            check("t4_alu_b_stable", alu_b[1], 8'h01);
            check("t4_alu_op_stable", alu_op[1], OP_ADD);
            check("t4_no_early_rsp", rv[1], 1'b0);
        end
        @(negedge clk);
        check("t4_rsp_valid", rv[1], 1'b1);
        check("t4_rsp_wrap", rd[1], 8'h00);
        check("t4_rsp_id", rid[1], 1'b0);
        wait_idle(1, "t4_idle");

        @(posedge clk); #1;
        set_req(1, 1, 1'b1, 8'h10, 8'h07, OP_SUB);
        @(negedge clk);
        check("t5_ready1_accept", r[1][1], 1'b1);
        @(posedge clk); #1;
        v[1][1] = 1'b0;
        rst[1]  = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("t5_busy", busy[1], 1'b0);
        check("t5_rsp_valid", rv[1], 1'b0);
        check("t5_alu_a", alu_a[1], 8'h00);
        check("t5_alu_b", alu_b[1], 8'h00);
        check("t5_alu_op", alu_op[1], 3'b000);
        check("t5_rsp_data", rd[1], 8'h00);
        check("t5_rsp_id", rid[1], 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rv[1] !== 1'b0) seen = 1'b1;
        end
        check("t5_no_ghost_rsp", seen, 1'b0);

        random_phase(1, 2000);
        done[1] = 1'b1;
    end

    initial begin : finisher
        wait (done[0] && done[1]);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
